// File: rtl/control_unit_pipe_pkg.sv
// cu_pkg: opcodes, ALU op codes, pipelined control bundle and beat-sequencer state
//   Shared by control_unit_pipe, control_unit_pipe_if and cu_vec_seq.
package cu_pkg;
   localparam logic [5:0] OP_ALU  = 6'b000000;
   localparam logic [5:0] OP_ALUI = 6'b000001;
   localparam logic [5:0] OP_LDR  = 6'b000100;
   localparam logic [5:0] OP_STR  = 6'b000101;
   localparam logic [5:0] OP_VALU = 6'b001000;
   localparam logic [5:0] OP_VLDR = 6'b001100;
   localparam logic [5:0] OP_VSTR = 6'b001101;
   localparam logic [5:0] OP_B    = 6'b010000;
   localparam logic [2:0] ALU_ADD = 3'b000;
   typedef struct packed {
      logic       RegWrite;
      logic       RegWriteV;
      logic       MemtoReg;
      logic       MemWrite;
      logic       MemSrc;
      logic       MemData;
      logic       VecData;
      logic [1:0] InstrSel;
      logic [2:0] ALUControl;
      logic       Branch;
      logic       ALUSrc;
   } ctrl_bundle_t;
   typedef enum logic {IDLE, BURST} seq_state_t;
   function automatic int beat_bits(input int beats);
      return beats > 1 ? $clog2(beats) : 1;
   endfunction
endpackage

// File: rtl/control_unit_pipe_if.sv
// control_unit_pipe_if: decode inputs, hazard controls and pipelined control outputs
//   master: instruction/hazard side (drives Opcode..CondExE, reads controls)
//   slave : control unit (reads Opcode..CondExE, drives RegSrcD..PCSrcW)
interface control_unit_pipe_if #(parameter int R = 5, parameter int BEATS = 4);
   localparam int BW = cu_pkg::beat_bits(BEATS);
   logic [5:0]    Opcode;
   logic [2:0]    Func;
   logic [R-1:0]  Rd;
   logic          InstrValidD, StallE, FlushE, CondExE;
   logic [1:0]    RegSrcD, ImmSrcD;
   logic          IllegalD;
   logic [2:0]    ALUControlE;
   logic          ALUSrcE;
   logic [1:0]    InstrSelE;
   logic          BranchE, PCSrcE;
   logic          MemWriteM, MemSrcM, MemDataM, VecDataM;
   logic [BW-1:0] BeatIdxM;
   logic          VecBusy;
   logic          RegWriteW, RegWriteVW, MemtoRegW, PCSrcW;
   modport master (
      output Opcode, Func, Rd, InstrValidD, StallE, FlushE, CondExE,
      input  RegSrcD, ImmSrcD, IllegalD, ALUControlE, ALUSrcE, InstrSelE, BranchE, PCSrcE,
             MemWriteM, MemSrcM, MemDataM, VecDataM, BeatIdxM, VecBusy,
             RegWriteW, RegWriteVW, MemtoRegW, PCSrcW
   );
   modport slave (
      input  Opcode, Func, Rd, InstrValidD, StallE, FlushE, CondExE,
      output RegSrcD, ImmSrcD, IllegalD, ALUControlE, ALUSrcE, InstrSelE, BranchE, PCSrcE,
             MemWriteM, MemSrcM, MemDataM, VecDataM, BeatIdxM, VecBusy,
             RegWriteW, RegWriteVW, MemtoRegW, PCSrcW
   );
endinterface

// File: rtl/control_unit_pipe_vec_seq.sv
// cu_vec_seq: vector memory beat sequencer holding M for BEATS cycles per vector access
//   in : clk, rst_n (async, active-low), vecmemM (vector load/store in M)
//   out: BeatIdxM (current beat), VecBusy (stall request, low on the final beat)
module cu_vec_seq import cu_pkg::*; #(
   parameter int BEATS = 4,
   localparam int BW = beat_bits(BEATS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          vecmemM,
   output logic [BW-1:0] BeatIdxM,
   output logic          VecBusy
);
   localparam logic [BW-1:0] LAST = BW'(BEATS - 1);
   seq_state_t state, state_nx;
   logic [BW-1:0] cnt, cnt_nx;
   logic last;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      last     = (state == BURST) && (cnt == LAST);
      case (state)
         IDLE:
            if (vecmemM && BEATS > 1) begin
               state_nx = BURST;
               cnt_nx   = BW'(1);
            end
         BURST:
            if (last) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else
               cnt_nx = cnt + 1'b1;
         default: state_nx = IDLE;
      endcase
      BeatIdxM = (state == BURST) ? cnt : '0;
      // the final beat releases the stall so the access leaves M next edge
      VecBusy  = (BEATS > 1) && vecmemM && !last;
   end
endmodule

// File: rtl/control_unit_pipe.sv
// control_unit_pipe: pipelined SIMD control unit with D/E/M/W control bundle and vector beat sequencer
//   clk, rst_n (async, active-low); bus (control_unit_pipe_if.slave): decode fields,
//   hazard controls in; decode selects, E/M/W controls, BeatIdxM/VecBusy out.
//   Optional CU_PC_WRITE_EN: carries Rd to W and flags writes to register PC_IDX on PCSrcW.
module control_unit_pipe import cu_pkg::*; #(
   parameter int R      = 5,
   parameter int PC_IDX = 31,
   parameter int LANES  = 4,
   parameter int BEATS  = 4
) (
   input logic clk,
   input logic rst_n,
   control_unit_pipe_if.slave bus
);
   localparam int unused_lanes = LANES;
   ctrl_bundle_t d, e, m, w;
   logic vec_busy, pcsrc_e, vecmem_m, unused_bits;
   always_comb begin
      d            = '0;
      bus.IllegalD = 1'b0;
      bus.RegSrcD  = 2'b00;
      bus.ImmSrcD  = 2'b00;
      case (bus.Opcode)
         OP_ALU: begin
            d.RegWrite   = 1'b1;
            d.ALUControl = bus.Func;
         end
         OP_ALUI: begin
            d.RegWrite   = 1'b1;
            d.ALUSrc     = 1'b1;
            d.ALUControl = bus.Func;
         end
         OP_LDR: begin
            d.RegWrite   = 1'b1;
            d.MemtoReg   = 1'b1;
            d.MemSrc     = 1'b1;
            d.ALUSrc     = 1'b1;
            d.ALUControl = ALU_ADD;
            bus.ImmSrcD  = 2'b01;
         end
         OP_STR: begin
            d.MemWrite   = 1'b1;
            d.MemSrc     = 1'b1;
            d.MemData    = 1'b1;
            d.ALUSrc     = 1'b1;
            d.ALUControl = ALU_ADD;
            bus.RegSrcD  = 2'b10;
            bus.ImmSrcD  = 2'b01;
         end
         OP_VALU: begin
            d.RegWriteV  = 1'b1;
            d.ALUControl = bus.Func;
         end
         OP_VLDR: begin
            d.RegWriteV  = 1'b1;
            d.MemtoReg   = 1'b1;
            d.MemSrc     = 1'b1;
            d.VecData    = 1'b1;
            d.ALUSrc     = 1'b1;
            d.ALUControl = ALU_ADD;
            bus.ImmSrcD  = 2'b01;
         end
         OP_VSTR: begin
            d.MemWrite   = 1'b1;
            d.MemSrc     = 1'b1;
            d.MemData    = 1'b1;
            d.VecData    = 1'b1;
            d.ALUSrc     = 1'b1;
            d.ALUControl = ALU_ADD;
            bus.RegSrcD  = 2'b10;
            bus.ImmSrcD  = 2'b01;
         end
         OP_B: begin
            d.Branch     = 1'b1;
            d.ALUSrc     = 1'b1;
            d.ALUControl = ALU_ADD;
            bus.RegSrcD  = 2'b01;
            bus.ImmSrcD  = 2'b10;
         end
         default: bus.IllegalD = 1'b1;
      endcase
      if (!bus.IllegalD) d.InstrSel = bus.Opcode[1:0];
   end
   // a branch held behind a burst resolves only in the cycle it advances
   assign pcsrc_e  = e.Branch & bus.CondExE & ~vec_busy;
   assign vecmem_m = m.VecData & (m.MemWrite | m.MemtoReg);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         e <= '0;
         m <= '0;
         w <= '0;
      end else begin
         if (bus.FlushE || pcsrc_e) e <= '0;
         else if (!(bus.StallE || vec_busy)) e <= bus.InstrValidD ? d : '0;
         if (!vec_busy) m <= e;
         // W only sees a vector access once, after its last beat
         w <= vec_busy ? '0 : m;
      end
   cu_vec_seq #(.BEATS(BEATS)) u_seq (
      .clk      (clk),
      .rst_n    (rst_n),
      .vecmemM  (vecmem_m),
      .BeatIdxM (bus.BeatIdxM),
      .VecBusy  (vec_busy)
   );
`ifdef CU_PC_WRITE_EN
   logic [R-1:0] rd_e, rd_m, rd_w;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rd_e <= '0;
         rd_m <= '0;
         rd_w <= '0;
      end else begin
         if (!(bus.StallE || vec_busy)) rd_e <= bus.Rd;
         if (!vec_busy) rd_m <= rd_e;
         rd_w <= rd_m;
      end
   assign bus.PCSrcW = w.RegWrite & (rd_w == R'(PC_IDX));
   assign unused_bits = 1'b0;
`else
   localparam int unused_pc_idx = PC_IDX;
   assign bus.PCSrcW  = 1'b0;
   assign unused_bits = ^bus.Rd;
`endif
   logic unused_w;
   assign unused_w = ^{w.MemWrite, w.MemSrc, w.MemData, w.VecData, w.InstrSel, w.ALUControl,
                       w.Branch, w.ALUSrc, unused_bits};
   assign bus.ALUControlE = e.ALUControl;
   assign bus.ALUSrcE     = e.ALUSrc;
   assign bus.InstrSelE   = e.InstrSel;
   assign bus.BranchE     = e.Branch;
   assign bus.PCSrcE      = pcsrc_e;
   assign bus.MemWriteM   = m.MemWrite;
   assign bus.MemSrcM     = m.MemSrc;
   assign bus.MemDataM    = m.MemData;
   assign bus.VecDataM    = m.VecData;
   assign bus.VecBusy     = vec_busy;
   assign bus.RegWriteW   = w.RegWrite;
   assign bus.RegWriteVW  = w.RegWriteV;
   assign bus.MemtoRegW   = w.MemtoReg;
endmodule

// File: tb/tb_control_unit_pipe.sv
// tb_control_unit_pipe: directed scoreboard bench for control_unit_pipe (BEATS=4)
module tb_control_unit_pipe;
   import cu_pkg::*;
   localparam int R = 5;
   localparam int BEATS = 4;
   localparam int S_ILL = 0, S_ALUC = 1, S_ALUSRC = 2, S_BRANCH = 3, S_PCSRCE = 4, S_MEMW = 5,
                  S_BEAT = 6, S_BUSY = 7, S_RW = 8, S_RWV = 9, S_M2R = 10, S_PCSRCW = 11,
                  S_EREGS = 12, S_VECD = 13, S_INSTRSEL = 14;
`ifdef CU_PC_WRITE_EN
   localparam logic PCW_EXP = 1'b1;
`else
   localparam logic PCW_EXP = 1'b0;
`endif
   typedef struct {
      int          due;
      int          sel;
      logic [31:0] exp;
      string       tag;
   } exp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int cyc = 0;
   int n_cmp = 0;
   int n_err = 0;
   exp_t sb[$];
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   control_unit_pipe_if #(.R(R), .BEATS(BEATS)) bus ();
   control_unit_pipe #(.R(R), .PC_IDX(31), .LANES(4), .BEATS(BEATS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );
   function automatic logic [31:0] regs_all();
      return 32'({bus.ALUControlE, bus.ALUSrcE, bus.InstrSelE, bus.BranchE, bus.PCSrcE,
                  bus.MemWriteM, bus.MemSrcM, bus.MemDataM, bus.VecDataM, bus.BeatIdxM,
                  bus.VecBusy, bus.RegWriteW, bus.RegWriteVW, bus.MemtoRegW, bus.PCSrcW});
   endfunction
   function automatic logic [31:0] obs(input int sel);
      case (sel)
         S_ILL:      return 32'(bus.IllegalD);
         S_ALUC:     return 32'(bus.ALUControlE);
         S_ALUSRC:   return 32'(bus.ALUSrcE);
         S_BRANCH:   return 32'(bus.BranchE);
         S_PCSRCE:   return 32'(bus.PCSrcE);
         S_MEMW:     return 32'(bus.MemWriteM);
         S_BEAT:     return 32'(bus.BeatIdxM);
         S_BUSY:     return 32'(bus.VecBusy);
         S_RW:       return 32'(bus.RegWriteW);
         S_RWV:      return 32'(bus.RegWriteVW);
         S_M2R:      return 32'(bus.MemtoRegW);
         S_PCSRCW:   return 32'(bus.PCSrcW);
         S_EREGS:    return 32'({bus.ALUControlE, bus.ALUSrcE, bus.InstrSelE, bus.BranchE});
         S_VECD:     return 32'(bus.VecDataM);
         S_INSTRSEL: return 32'(bus.InstrSelE);
         default:    return 32'hdead_beef;
      endcase
   endfunction
   always @(negedge clk) begin : mon
      logic [31:0] o;
      for (int i = sb.size() - 1; i >= 0; i--)
         if (sb[i].due == cyc) begin
            o = obs(sb[i].sel);
            n_cmp++;
            assert (o === sb[i].exp) else begin
               n_err++;
               $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", sb[i].tag, o, sb[i].exp, cyc);
            end
            sb.delete(i);
         end
   end
   task automatic check_now(input string tag, input logic [31:0] o, input logic [31:0] e);
      n_cmp++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
      end
   endtask
   task automatic expect_at(input int dly, input int sel, input logic [31:0] e, input string tag);
      sb.push_back('{cyc + dly, sel, e, tag});
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input logic [5:0] op, input logic [2:0] f, input logic [R-1:0] rd, input logic v);
      bus.Opcode      = op;
      bus.Func        = f;
      bus.Rd          = rd;
      bus.InstrValidD = v;
   endtask
   task automatic idle(input int n);
      repeat (n) begin
         drive(6'b0, 3'b0, '0, 1'b0);
         tick();
      end
   endtask
   initial begin
      drive(6'b0, 3'b0, '0, 1'b0);
      bus.StallE  = 1'b0;
      bus.FlushE  = 1'b0;
      bus.CondExE = 1'b0;
      repeat (3) tick();
      check_now("reset_regs", regs_all(), 32'h0);
      rst_n = 1'b1;
      tick();
      // scalar latency: ALU, STR, LDR back to back
      drive(OP_ALU, 3'b010, 5'd3, 1'b1);
      expect_at(0, S_ILL, 0, "alu_illegal");
      expect_at(1, S_ALUC, 3'b010, "alu_aluc");
      expect_at(3, S_RW, 1, "alu_regwrite_w");
      expect_at(3, S_M2R, 0, "alu_memtoreg_w");
      tick();
      drive(OP_STR, 3'b111, 5'd4, 1'b1);
      expect_at(1, S_ALUC, 3'b000, "str_aluc_add");
      expect_at(1, S_ALUSRC, 1, "str_alusrc");
      expect_at(2, S_MEMW, 1, "str_memwrite_m");
      expect_at(2, S_BUSY, 0, "str_not_busy");
      expect_at(3, S_RW, 0, "str_no_regwrite");
      tick();
      drive(OP_LDR, 3'b000, 5'd5, 1'b1);
      expect_at(2, S_MEMW, 0, "ldr_no_memwrite");
      expect_at(3, S_RW, 1, "ldr_regwrite_w");
      expect_at(3, S_M2R, 1, "ldr_memtoreg_w");
      tick();
      idle(4);
      // VSTR burst followed by VALU held in E
      drive(OP_VSTR, 3'b000, '0, 1'b1);
      expect_at(2, S_VECD, 1, "vstr_vecdata");
      for (int i = 0; i < 4; i++) begin
         expect_at(2 + i, S_BEAT, i, $sformatf("vstr_beat%0d", i));
         expect_at(2 + i, S_MEMW, 1, $sformatf("vstr_memw%0d", i));
         expect_at(2 + i, S_BUSY, i < 3, $sformatf("vstr_busy%0d", i));
         expect_at(2 + i, S_ALUC, 3'b101, $sformatf("valu_held%0d", i));
      end
      expect_at(6, S_MEMW, 0, "vstr_memw_end");
      expect_at(6, S_ALUC, 3'b000, "valu_left_e");
      expect_at(6, S_RWV, 0, "valu_rwv_early");
      expect_at(7, S_RWV, 1, "valu_rwv_w");
      tick();
      drive(OP_VALU, 3'b101, '0, 1'b1);
      tick();
      idle(7);
      // VLDR writes back once after its last beat
      drive(OP_VLDR, 3'b000, '0, 1'b1);
      expect_at(4, S_RW, 0, "vldr_w_bubble");
      expect_at(5, S_RWV, 0, "vldr_rwv_before");
      expect_at(6, S_RWV, 1, "vldr_rwv_w");
      expect_at(6, S_M2R, 1, "vldr_memtoreg_w");
      expect_at(7, S_RWV, 0, "vldr_rwv_once");
      tick();
      idle(8);
      // taken branch self-flushes the following instruction
      bus.CondExE = 1'b1;
      drive(OP_B, 3'b000, '0, 1'b1);
      expect_at(1, S_BRANCH, 1, "b_branch_e");
      expect_at(1, S_PCSRCE, 1, "b_pcsrc_e");
      expect_at(2, S_PCSRCE, 0, "b_pcsrc_once");
      expect_at(2, S_ALUC, 3'b000, "b_shadow_bubbled");
      expect_at(4, S_RW, 0, "b_shadow_no_write");
      tick();
      drive(OP_ALU, 3'b011, '0, 1'b1);
      tick();
      idle(5);
      // branch behind a burst fires once when it advances
      drive(OP_VSTR, 3'b000, '0, 1'b1);
      expect_at(2, S_PCSRCE, 0, "bbusy_pcsrc0");
      expect_at(4, S_PCSRCE, 0, "bbusy_pcsrc2");
      expect_at(5, S_BRANCH, 1, "bbusy_branch_e");
      expect_at(5, S_PCSRCE, 1, "bbusy_pcsrc_fire");
      expect_at(6, S_PCSRCE, 0, "bbusy_pcsrc_once");
      tick();
      drive(OP_B, 3'b000, '0, 1'b1);
      tick();
      idle(7);
      // untaken branch does not flush
      bus.CondExE = 1'b0;
      drive(OP_B, 3'b000, '0, 1'b1);
      expect_at(1, S_BRANCH, 1, "bnt_branch_e");
      expect_at(1, S_PCSRCE, 0, "bnt_pcsrc_e");
      tick();
      drive(OP_ALU, 3'b011, '0, 1'b1);
      expect_at(1, S_ALUC, 3'b011, "bnt_next_kept");
      tick();
      idle(4);
      // flush wins over VecBusy at D->E while E->M holds
      drive(OP_VSTR, 3'b000, '0, 1'b1);
      tick();
      drive(OP_ALU, 3'b110, '0, 1'b1);
      expect_at(1, S_ALUC, 3'b110, "flush_alu_in_e");
      tick();
      drive(6'b0, 3'b0, '0, 1'b0);
      bus.FlushE = 1'b1;
      expect_at(1, S_ALUC, 3'b000, "flush_wins");
      expect_at(1, S_MEMW, 1, "flush_m_holds");
      expect_at(1, S_BEAT, 1, "flush_beat1");
      expect_at(1, S_BUSY, 1, "flush_busy");
      tick();
      bus.FlushE = 1'b0;
      idle(6);
      // StallE holds the D->E register
      drive(OP_ALU, 3'b001, '0, 1'b1);
      expect_at(1, S_ALUC, 3'b001, "stall_first");
      tick();
      drive(OP_ALUI, 3'b100, '0, 1'b1);
      bus.StallE = 1'b1;
      expect_at(1, S_ALUC, 3'b001, "stall_hold");
      tick();
      bus.StallE = 1'b0;
      expect_at(1, S_ALUC, 3'b100, "stall_release");
      expect_at(1, S_ALUSRC, 1, "alui_alusrc");
      expect_at(1, S_INSTRSEL, 2'b01, "alui_instrsel");
      tick();
      idle(4);
      // illegal opcode decodes to a zero bundle
      drive(6'b111111, 3'b111, 5'd31, 1'b1);
      expect_at(0, S_ILL, 1, "illegal_d");
      expect_at(1, S_EREGS, 0, "illegal_zero_e");
      expect_at(3, S_RW, 0, "illegal_no_write");
      tick();
      idle(4);
      // writes to the PC register
      drive(OP_ALU, 3'b000, 5'd31, 1'b1);
      expect_at(3, S_PCSRCW, PCW_EXP, "pcw_rd31");
      tick();
      drive(OP_ALU, 3'b000, 5'd30, 1'b1);
      expect_at(3, S_PCSRCW, 0, "pcw_rd30");
      tick();
      idle(5);
      // reset in the middle of a burst
      drive(OP_VSTR, 3'b000, '0, 1'b1);
      tick();
      idle(2);
      check_now("pre_reset_busy", 32'(bus.VecBusy), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check_now("midburst_reset_regs", regs_all(), 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      drive(OP_ALU, 3'b010, '0, 1'b1);
      expect_at(1, S_ALUC, 3'b010, "post_reset_alu");
      expect_at(1, S_BEAT, 0, "post_reset_beat");
      tick();
      idle(4);
      foreach (sb[i]) begin
         n_err++;
         $display("FAIL %s: expected=%0h never compared (due cycle %0d)", sb[i].tag, sb[i].exp, sb[i].due);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
